// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register, collision flag and post-reset clear.
module tdp_ram_be #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int BYTE_W         = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en_a,
    input  logic [DATA_W/BYTE_W-1:0] i_wen_a,
    input  logic [ADDR_W-1:0]        i_addr_a,
    input  logic [DATA_W-1:0]        i_din_a,
    output logic [DATA_W-1:0]        o_dout_a,
    output logic                     o_valid_a,
    input  logic                     i_en_b,
    input  logic [DATA_W/BYTE_W-1:0] i_wen_b,
    input  logic [ADDR_W-1:0]        i_addr_b,
    input  logic [DATA_W-1:0]        i_din_b,
    output logic [DATA_W-1:0]        o_dout_b,
    output logic                     o_valid_b,
    output logic                     o_collision,
    output logic                     o_ready
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_clr_we;
    logic              w_ready;

    // Index 0 is port A, index 1 is port B.
    logic              w_en    [2];
    logic [NB-1:0]     w_wen   [2];
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_din   [2];
    logic              w_acc   [2];
    logic              w_wr    [2];
    logic              w_rvld  [2];
    logic [DATA_W-1:0] w_old   [2];
    logic [DATA_W-1:0] w_mask  [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_coll;

    logic [DATA_W-1:0] r_d1   [2];
    logic              r_v1   [2];
    logic [DATA_W-1:0] r_dout [2];
    logic              r_vld  [2];
    logic              r_coll;

    assign w_en[0]   = i_en_a;
    assign w_en[1]   = i_en_b;
    assign w_wen[0]  = i_wen_a;
    assign w_wen[1]  = i_wen_b;
    assign w_addr[0] = i_addr_a;
    assign w_addr[1] = i_addr_b;
    assign w_din[0]  = i_din_a;
    assign w_din[1]  = i_din_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_cnt == '1) begin
            w_state_nxt = S_RUN;
        end
    end

    always_comb begin
        w_clr_we = (r_state == S_CLEAR);
        w_ready  = (r_state == S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            w_mask[p] = '0;
            for (int unsigned k = 0; k < NB; k++) begin
                w_mask[p][k*BYTE_W +: BYTE_W] = {BYTE_W{w_wen[p][k]}};
            end
            w_old[p]  = r_mem[w_addr[p]];
            w_acc[p]  = w_ready & w_en[p];
            w_wr[p]   = w_acc[p] & (|w_wen[p]);
            w_rvld[p] = w_acc[p] & ~(w_wr[p] & (RDW_MODE == 2));
            if (w_wr[p] && RDW_MODE == 0) begin
                w_rdata[p] = (w_din[p] & w_mask[p]) | (w_old[p] & ~w_mask[p]);
            end else begin
                w_rdata[p] = w_old[p];
            end
        end
        w_coll = w_acc[0] & w_acc[1] & (w_addr[0] == w_addr[1]) & (w_wr[0] | w_wr[1]);
    end

    // Port B's lane writes are issued after port A's, so B wins on shared lanes.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (w_wr[p] && w_wen[p][k]) begin
                        r_mem[w_addr[p]][k*BYTE_W +: BYTE_W] <= w_din[p][k*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned p = 0; p < 2; p++) begin
                r_d1[p]   <= '0;
                r_v1[p]   <= 1'b0;
                r_dout[p] <= '0;
                r_vld[p]  <= 1'b0;
            end
            r_coll <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                r_v1[p] <= w_rvld[p];
                if (w_rvld[p]) begin
                    r_d1[p] <= w_rdata[p];
                end
                if (OUT_REG != 0) begin
                    r_vld[p] <= r_v1[p];
                    if (r_v1[p]) begin
                        r_dout[p] <= r_d1[p];
                    end
                end else begin
                    r_vld[p] <= w_rvld[p];
                    if (w_rvld[p]) begin
                        r_dout[p] <= w_rdata[p];
                    end
                end
            end
            r_coll <= w_coll;
        end
    end

    assign o_dout_a    = r_dout[0];
    assign o_valid_a   = r_vld[0];
    assign o_dout_b    = r_dout[1];
    assign o_valid_b   = r_vld[1];
    assign o_collision = r_coll;
    assign o_ready     = w_ready;

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: three instances (write-first/lat1, read-first/lat2,
// no-change/lat1) share stimulus and are checked against one array model.
module tb_tdp_ram_be;
    localparam int DEPTH = 16;
    localparam int ND    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [1:0]  wen_a, wen_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic [15:0] dout_a [ND];
    logic [15:0] dout_b [ND];
    logic        valid_a [ND];
    logic        valid_b [ND];
    logic        coll [ND];
    logic        ready [ND];

    always #5 clk = ~clk;

    tdp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_wen_a(wen_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(dout_a[0]), .o_valid_a(valid_a[0]),
        .i_en_b(en_b), .i_wen_b(wen_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(dout_b[0]), .o_valid_b(valid_b[0]),
        .o_collision(coll[0]), .o_ready(ready[0]));
    tdp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_wen_a(wen_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(dout_a[1]), .o_valid_a(valid_a[1]),
        .i_en_b(en_b), .i_wen_b(wen_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(dout_b[1]), .o_valid_b(valid_b[1]),
        .o_collision(coll[1]), .o_ready(ready[1]));
    tdp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_wen_a(wen_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(dout_a[2]), .o_valid_a(valid_a[2]),
        .i_en_b(en_b), .i_wen_b(wen_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(dout_b[2]), .o_valid_b(valid_b[2]),
        .o_collision(coll[2]), .o_ready(ready[2]));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mm [DEPTH];
    bit          m_ready;
    int          m_clr;
    logic [15:0] ed_a [ND], ed_b [ND], s1d_a [ND], s1d_b [ND];
    bit          ev_a [ND], ev_b [ND], s1v_a [ND], s1v_b [ND];
    bit          ecoll;

    function automatic int mode_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
    endfunction

    function automatic bit oreg_of(int d);
        return d == 1;
    endfunction

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] din, logic [1:0] wen);
        logic [15:0] r;
        r = old;
        if (wen[0]) r[7:0]  = din[7:0];
        if (wen[1]) r[15:8] = din[15:8];
        return r;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_clr   = 0;
        ecoll   = 1'b0;
        for (int d = 0; d < ND; d++) begin
            ed_a[d] = '0; ed_b[d] = '0; s1d_a[d] = '0; s1d_b[d] = '0;
            ev_a[d] = 1'b0; ev_b[d] = 1'b0; s1v_a[d] = 1'b0; s1v_b[d] = 1'b0;
        end
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; wen_a = '0; wen_b = '0;
    endtask

    // One clock: evaluate requests on the pre-edge array, then advance the model.
    task automatic step();
        bit acc_a, acc_b, wr_a, wr_b, ncoll;
        logic [15:0] old_a, old_b;
        bit nv_a [ND], nv_b [ND];
        logic [15:0] nd_a [ND], nd_b [ND];
        acc_a = m_ready && en_a;
        acc_b = m_ready && en_b;
        wr_a  = acc_a && (wen_a != 0);
        wr_b  = acc_b && (wen_b != 0);
        old_a = mm[addr_a];
        old_b = mm[addr_b];
        for (int d = 0; d < ND; d++) begin
            nv_a[d] = acc_a && !(wr_a && mode_of(d) == 2);
            nd_a[d] = (wr_a && mode_of(d) == 0) ? merge(old_a, din_a, wen_a) : old_a;
            nv_b[d] = acc_b && !(wr_b && mode_of(d) == 2);
            nd_b[d] = (wr_b && mode_of(d) == 0) ? merge(old_b, din_b, wen_b) : old_b;
        end
        ncoll = acc_a && acc_b && (addr_a == addr_b) && (wr_a || wr_b);
        @(posedge clk);
        #1;
        ecoll = ncoll;
        for (int d = 0; d < ND; d++) begin
            if (oreg_of(d)) begin
                ev_a[d] = s1v_a[d]; if (s1v_a[d]) ed_a[d] = s1d_a[d];
                ev_b[d] = s1v_b[d]; if (s1v_b[d]) ed_b[d] = s1d_b[d];
                s1v_a[d] = nv_a[d]; if (nv_a[d]) s1d_a[d] = nd_a[d];
                s1v_b[d] = nv_b[d]; if (nv_b[d]) s1d_b[d] = nd_b[d];
            end else begin
                ev_a[d] = nv_a[d]; if (nv_a[d]) ed_a[d] = nd_a[d];
                ev_b[d] = nv_b[d]; if (nv_b[d]) ed_b[d] = nd_b[d];
            end
        end
        if (!m_ready) begin
            mm[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) m_ready = 1'b1;
        end else begin
            if (wr_a) mm[addr_a] = merge(mm[addr_a], din_a, wen_a);
            if (wr_b) mm[addr_b] = merge(mm[addr_b], din_b, wen_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++; if (dout_a[d] !== 16'h0) begin errors++; $display("FAIL reset_dout_a[%0d]: got %h expected 0000", d, dout_a[d]); end
            checks++; if (dout_b[d] !== 16'h0) begin errors++; $display("FAIL reset_dout_b[%0d]: got %h expected 0000", d, dout_b[d]); end
            checks++; if (valid_a[d] !== 1'b0 || valid_b[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b%b expected 00", d, valid_a[d], valid_b[d]); end
            checks++; if (coll[d] !== 1'b0) begin errors++; $display("FAIL reset_coll[%0d]: got %b expected 0", d, coll[d]); end
            checks++; if (ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, ready[d]); end
        end
    endtask

    task automatic test_clear();
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            en_a = 1'b1; en_b = 1'b1;
            wen_a = 2'($urandom_range(0, 3)); wen_b = 2'($urandom_range(0, 3));
            addr_a = 4'($urandom_range(0, 15)); addr_b = 4'($urandom_range(0, 15));
            din_a = 16'($urandom); din_b = 16'($urandom);
            step();
            cnt++;
            for (int d = 0; d < ND; d++) begin
                checks++; if (valid_a[d] !== 1'b0 || valid_b[d] !== 1'b0) begin errors++; $display("FAIL clear_valid[%0d] cycle %0d: got %b%b expected 00", d, cnt, valid_a[d], valid_b[d]); end
            end
            if (ready[0] === 1'b1) got = 1'b1;
        end
        checks++; if (cnt != 16 || !got) begin errors++; $display("FAIL clear_length: got %0d cycles (ready seen %0d) expected 16", cnt, got); end
        for (int d = 1; d < ND; d++) begin
            checks++; if (ready[d] !== 1'b1) begin errors++; $display("FAIL clear_ready[%0d]: got %b expected 1", d, ready[d]); end
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            en_b = 1'b1; wen_b = '0; addr_b = 4'(i);
            step();
            checks++; if (dout_b[0] !== 16'h0 || valid_b[0] !== 1'b1) begin errors++; $display("FAIL clear_read addr %0d: got %h/%b expected 0000/1", i, dout_b[0], valid_b[0]); end
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        en_a = 1'b1; wen_a = 2'b11; addr_a = 4'd3; din_a = 16'hBEEF;
        step();
        checks++; if (dout_a[0] !== 16'hBEEF || valid_a[0] !== 1'b1) begin errors++; $display("FAIL wr_first_a: got %h/%b expected BEEF/1", dout_a[0], valid_a[0]); end
        checks++; if (valid_a[2] !== 1'b0) begin errors++; $display("FAIL wr_nochange_valid_a: got %b expected 0", valid_a[2]); end
        idle();
        en_b = 1'b1; wen_b = '0; addr_b = 4'd3;
        step();
        idle();
        checks++; if (dout_b[0] !== 16'hBEEF || valid_b[0] !== 1'b1) begin errors++; $display("FAIL rd_lat1_b: got %h/%b expected BEEF/1", dout_b[0], valid_b[0]); end
        checks++; if (valid_b[1] !== 1'b0) begin errors++; $display("FAIL rd_lat2_early_b: got %b expected 0", valid_b[1]); end
        step();
        checks++; if (dout_b[1] !== 16'hBEEF || valid_b[1] !== 1'b1) begin errors++; $display("FAIL rd_lat2_b: got %h/%b expected BEEF/1", dout_b[1], valid_b[1]); end
        checks++; if (dout_b[0] !== 16'hBEEF || valid_b[0] !== 1'b0) begin errors++; $display("FAIL rd_hold_b: got %h/%b expected BEEF/0", dout_b[0], valid_b[0]); end
        step();
    endtask

    task automatic test_byte_lanes();
        logic [15:0] hold2;
        en_a = 1'b1; wen_a = 2'b11; addr_a = 4'd5; din_a = 16'h1234;
        step();
        idle();
        step();
        step();
        hold2 = ed_a[2];
        en_a = 1'b1; wen_a = 2'b01; addr_a = 4'd5; din_a = 16'hABCD;
        step();
        idle();
        checks++; if (dout_a[0] !== 16'h12CD || valid_a[0] !== 1'b1) begin errors++; $display("FAIL lane_wfirst: got %h/%b expected 12CD/1", dout_a[0], valid_a[0]); end
        checks++; if (dout_a[2] !== hold2 || valid_a[2] !== 1'b0) begin errors++; $display("FAIL lane_nochange: got %h/%b expected %h/0", dout_a[2], valid_a[2], hold2); end
        step();
        checks++; if (dout_a[1] !== 16'h1234 || valid_a[1] !== 1'b1) begin errors++; $display("FAIL lane_rfirst: got %h/%b expected 1234/1", dout_a[1], valid_a[1]); end
        en_b = 1'b1; wen_b = '0; addr_b = 4'd5;
        step();
        idle();
        checks++; if (dout_b[0] !== 16'h12CD) begin errors++; $display("FAIL lane_mem: got %h expected 12CD", dout_b[0]); end
        step();
    endtask

    task automatic test_collision_ww();
        en_a = 1'b1; wen_a = 2'b11; addr_a = 4'd7; din_a = 16'h1111;
        en_b = 1'b1; wen_b = 2'b10; addr_b = 4'd7; din_b = 16'h2222;
        step();
        idle();
        for (int d = 0; d < ND; d++) begin
            checks++; if (coll[d] !== 1'b1) begin errors++; $display("FAIL ww_coll[%0d]: got %b expected 1", d, coll[d]); end
        end
        step();
        checks++; if (coll[0] !== 1'b0 || coll[1] !== 1'b0) begin errors++; $display("FAIL ww_coll_pulse: got %b%b expected 00", coll[0], coll[1]); end
        en_b = 1'b1; wen_b = '0; addr_b = 4'd7;
        step();
        idle();
        checks++; if (dout_b[0] !== 16'h2211) begin errors++; $display("FAIL ww_mem: got %h expected 2211", dout_b[0]); end
        step();
    endtask

    task automatic test_collision_rw();
        en_a = 1'b1; wen_a = 2'b11; addr_a = 4'd9; din_a = 16'h00AA;
        step();
        idle();
        step();
        step();
        en_a = 1'b1; wen_a = '0; addr_a = 4'd9;
        en_b = 1'b1; wen_b = 2'b11; addr_b = 4'd9; din_b = 16'h5555;
        step();
        idle();
        checks++; if (coll[0] !== 1'b1 || coll[2] !== 1'b1) begin errors++; $display("FAIL rw_coll: got %b%b expected 11", coll[0], coll[2]); end
        checks++; if (dout_a[0] !== 16'h00AA || valid_a[0] !== 1'b1) begin errors++; $display("FAIL rw_read_old: got %h/%b expected 00AA/1", dout_a[0], valid_a[0]); end
        checks++; if (dout_b[0] !== 16'h5555 || valid_b[0] !== 1'b1) begin errors++; $display("FAIL rw_write_port: got %h/%b expected 5555/1", dout_b[0], valid_b[0]); end
        step();
        checks++; if (coll[1] !== 1'b0) begin errors++; $display("FAIL rw_coll_not_delayed: got %b expected 0", coll[1]); end
        checks++; if (dout_a[1] !== 16'h00AA || dout_b[1] !== 16'h00AA) begin errors++; $display("FAIL rw_lat2_old: got %h/%h expected 00AA/00AA", dout_a[1], dout_b[1]); end
        en_b = 1'b1; wen_b = '0; addr_b = 4'd9;
        step();
        idle();
        checks++; if (dout_b[0] !== 16'h5555) begin errors++; $display("FAIL rw_mem: got %h expected 5555", dout_b[0]); end
        step();
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            en_a = ($urandom_range(0, 3) != 0);
            en_b = ($urandom_range(0, 3) != 0);
            wen_a = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            wen_b = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            addr_a = 4'($urandom_range(0, 15));
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom_range(0, 15));
            din_a = 16'($urandom); din_b = 16'($urandom);
            step();
            for (int d = 0; d < ND; d++) begin
                checks++; if (dout_a[d] !== ed_a[d] || valid_a[d] !== ev_a[d]) begin errors++; $display("FAIL rand_a[%0d] cycle %0d: got %h/%b expected %h/%b", d, c, dout_a[d], valid_a[d], ed_a[d], ev_a[d]); end
                checks++; if (dout_b[d] !== ed_b[d] || valid_b[d] !== ev_b[d]) begin errors++; $display("FAIL rand_b[%0d] cycle %0d: got %h/%b expected %h/%b", d, c, dout_b[d], valid_b[d], ed_b[d], ev_b[d]); end
                checks++; if (coll[d] !== ecoll) begin errors++; $display("FAIL rand_coll[%0d] cycle %0d: got %b expected %b", d, c, coll[d], ecoll); end
            end
        end
        idle();
        step();
        step();
    endtask

    task automatic test_reset_midstream();
        en_a = 1'b1; wen_a = '0; addr_a = 4'd3;
        en_b = 1'b1; wen_b = '0; addr_b = 4'd9;
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++; if (dout_a[d] !== 16'h0 || dout_b[d] !== 16'h0) begin errors++; $display("FAIL midrst_dout[%0d]: got %h/%h expected 0000/0000", d, dout_a[d], dout_b[d]); end
            checks++; if (valid_a[d] !== 1'b0 || valid_b[d] !== 1'b0 || ready[d] !== 1'b0) begin errors++; $display("FAIL midrst_flags[%0d]: got %b%b%b expected 000", d, valid_a[d], valid_b[d], ready[d]); end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                checks++; if (valid_a[d] !== ev_a[d] || valid_b[d] !== ev_b[d] || ready[d] !== m_ready) begin errors++; $display("FAIL midrst_seq[%0d] cycle %0d: got %b%b%b expected %b%b%b", d, c, valid_a[d], valid_b[d], ready[d], ev_a[d], ev_b[d], m_ready); end
            end
        end
        idle();
        en_a = 1'b1; wen_a = '0; addr_a = 4'd3;
        step();
        idle();
        checks++; if (dout_a[0] !== 16'h0 || valid_a[0] !== 1'b1) begin errors++; $display("FAIL midrst_cleared: got %h/%b expected 0000/1", dout_a[0], valid_a[0]); end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_byte_lanes();
        test_collision_ww();
        test_collision_rw();
        test_random(400);
        test_reset_midstream();
        test_random(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
